// File: rtl/cic_region_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cic_region_ctrl : CIC settle / retry / region-flip sequencer with lock
//                   qualification and system-hold control.   Rev 1.0
// ---------------------------------------------------------------------------
module cic_region_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 32767,
  parameter int unsigned LOCK_CYCLES   = 65535,
  parameter int unsigned MAX_TRIES     = 4,
  parameter bit          INIT_REGION   = 1'b0
) (
  input  logic       MCLKO,
  input  logic       RESETI,
  input  logic       CIC_FAIL,
  input  logic       FORCE_REQ,
  input  logic       FORCE_REGION,
  output logic       CIC_EN,
  output logic       REGION,
  output logic       SYS_HOLD,
  output logic       LOCKED,
  output logic       GIVEUP,
  output logic [2:0] TRIES
);

  localparam int unsigned MAX_CNT = (SETTLE_CYCLES > LOCK_CYCLES) ? SETTLE_CYCLES : LOCK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]       TRIES_LAST  = 3'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_RUN    = 3'd1,
    ST_LOCKED = 3'd2,
    ST_FAIL   = 3'd3,
    ST_GIVEUP = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, fail_s_q;
  logic             region_q, region_d;
  logic [2:0]       tries_q, tries_d;
  logic             cic_en_q, cic_en_d;
  logic             sys_hold_q, sys_hold_d;
  logic             locked_q, locked_d;
  logic             giveup_q, giveup_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    region_d = region_q;
    tries_d  = tries_q;
    if (FORCE_REQ) begin
      state_d  = ST_HOLD;
      cnt_d    = '0;
      region_d = FORCE_REGION;
      tries_d  = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (fail_s_q)                state_d = ST_FAIL;
          else if (cnt_q == LOCK_LAST) state_d = ST_LOCKED;
          else                         cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_LOCKED: begin
          if (fail_s_q) state_d = ST_FAIL;
        end
        ST_FAIL: begin
          // Last attempt keeps REGION/TRIES as they were when it failed.
          if (tries_q == TRIES_LAST) begin
            state_d = ST_GIVEUP;
          end else begin
            state_d  = ST_HOLD;
            region_d = ~region_q;
            tries_d  = tries_q + 3'd1;
            cnt_d    = '0;
          end
        end
        ST_GIVEUP: state_d = ST_GIVEUP;
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they move on the state's edge.
  always_comb begin
    cic_en_d   = (state_d == ST_RUN) || (state_d == ST_LOCKED);
    sys_hold_d = (state_d != ST_LOCKED);
    locked_d   = (state_d == ST_LOCKED);
    giveup_d   = (state_d == ST_GIVEUP);
  end

  always_ff @(posedge MCLKO or posedge RESETI) begin
    if (RESETI) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      sync1_q    <= 1'b0;
      fail_s_q   <= 1'b0;
      region_q   <= INIT_REGION;
      tries_q    <= '0;
      cic_en_q   <= 1'b0;
      sys_hold_q <= 1'b1;
      locked_q   <= 1'b0;
      giveup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync1_q    <= CIC_FAIL;
      fail_s_q   <= sync1_q;
      region_q   <= region_d;
      tries_q    <= tries_d;
      cic_en_q   <= cic_en_d;
      sys_hold_q <= sys_hold_d;
      locked_q   <= locked_d;
      giveup_q   <= giveup_d;
    end
  end

  assign CIC_EN   = cic_en_q;
  assign REGION   = region_q;
  assign SYS_HOLD = sys_hold_q;
  assign LOCKED   = locked_q;
  assign GIVEUP   = giveup_q;
  assign TRIES    = tries_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_region_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cic_region_ctrl : directed scoreboard bench for cic_region_ctrl.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_cic_region_ctrl;

  localparam int S = 8;
  localparam int L = 16;
  localparam int M = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cic_fail = 1'b0;
  logic       force_req = 1'b0;
  logic       force_region = 1'b0;
  logic       cic_en, region, sys_hold, locked, giveup;
  logic [2:0] tries;

  cic_region_ctrl #(
    .SETTLE_CYCLES(S),
    .LOCK_CYCLES  (L),
    .MAX_TRIES    (M),
    .INIT_REGION  (1'b0)
  ) u_dut (
    .MCLKO       (clk),
    .RESETI      (rst),
    .CIC_FAIL    (cic_fail),
    .FORCE_REQ   (force_req),
    .FORCE_REGION(force_region),
    .CIC_EN      (cic_en),
    .REGION      (region),
    .SYS_HOLD    (sys_hold),
    .LOCKED      (locked),
    .GIVEUP      (giveup),
    .TRIES       (tries)
  );

  always #5 clk = ~clk;

  // Edge 1 is the first rising edge after reset falls.
  int edge_n;
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  typedef struct {
    int         e;
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Packed as {CIC_EN, REGION, SYS_HOLD, LOCKED, GIVEUP, TRIES[2:0]}.
  function automatic logic [7:0] pk(input logic en, input logic rg, input logic hd,
                                    input logic lk, input logic gu, input logic [2:0] t);
    return {en, rg, hd, lk, gu, t};
  endfunction

  function automatic logic [7:0] obs();
    return {cic_en, region, sys_hold, locked, giveup, tries};
  endfunction

  task automatic push(input int e, input logic [7:0] v, input string tag);
    exp_t it;
    it.e   = e;
    it.v   = v;
    it.tag = tag;
    sb.push_back(it);
  endtask

  task automatic check_now(input logic [7:0] v, input string tag);
    tests_run++;
    assert (obs() === v) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs(), v);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e <= edge_n) begin
      cur = sb.pop_front();
      tests_run++;
      if (cur.e < edge_n) begin
        tests_failed++;
        $display("FAIL %s missed edge observed=%0d expected=%0d", cur.tag, edge_n, cur.e);
      end else begin
        assert (obs() === cur.v) else begin
          tests_failed++;
          $error("FAIL %s edge=%0d observed=%b expected=%b", cur.tag, edge_n, obs(), cur.v);
        end
      end
    end
  end

  task automatic wait_edge(input int n);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (edge_n < n && g < 1000);
    if (edge_n < n) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_edge observed=%0d expected=%0d", edge_n, n);
    end
  endtask

  task automatic clean_lock_expect(input string pfx);
    push(1,     pk(0, 0, 1, 0, 0, 3'd0), {pfx, "_hold_e1"});
    push(S - 1, pk(0, 0, 1, 0, 0, 3'd0), {pfx, "_pre_en"});
    push(S,     pk(1, 0, 1, 0, 0, 3'd0), {pfx, "_en_rise"});
    push(S+L-1, pk(1, 0, 1, 0, 0, 3'd0), {pfx, "_pre_lock"});
    push(S+L,   pk(1, 0, 0, 1, 0, 3'd0), {pfx, "_lock"});
  endtask

  task automatic restart(input logic fail_level);
    @(negedge clk);
    rst = 1'b1;
    cic_fail = fail_level;
    @(negedge clk);
  endtask

  initial begin
    // Clean lock from power-up
    #12;
    check_now(pk(0, 0, 1, 0, 0, 3'd0), "reset_state");
    @(negedge clk);
    clean_lock_expect("clean");
    rst = 1'b0;
    wait_edge(30);

    // Asynchronous reset in LOCKED, then the clean sequence again
    #2 rst = 1'b1;
    #1 check_now(pk(0, 0, 1, 0, 0, 3'd0), "rst_async");
    @(negedge clk);
    clean_lock_expect("relock");
    rst = 1'b0;
    wait_edge(30);

    // Single 3-cycle failure during RUN, CIC_FAIL rising before edge 11
    restart(1'b0);
    push(12, pk(1, 0, 1, 0, 0, 3'd0), "single_run");
    push(13, pk(0, 0, 1, 0, 0, 3'd0), "single_fail_state");
    push(14, pk(0, 1, 1, 0, 0, 3'd1), "single_region_flip");
    push(21, pk(0, 1, 1, 0, 0, 3'd1), "single_pre_en");
    push(22, pk(1, 1, 1, 0, 0, 3'd1), "single_en_rise");
    push(37, pk(1, 1, 1, 0, 0, 3'd1), "single_pre_lock");
    push(38, pk(1, 1, 0, 1, 0, 3'd1), "single_lock");
    rst = 1'b0;
    wait_edge(10);
    cic_fail = 1'b1;
    wait_edge(13);
    cic_fail = 1'b0;
    wait_edge(40);

    // Persistent failure from reset until give-up
    restart(1'b1);
    push(8,   pk(1, 0, 1, 0, 0, 3'd0), "pers_run1");
    push(9,   pk(0, 0, 1, 0, 0, 3'd0), "pers_fail1");
    push(10,  pk(0, 1, 1, 0, 0, 3'd1), "pers_hold2");
    push(18,  pk(1, 1, 1, 0, 0, 3'd1), "pers_run2");
    push(19,  pk(0, 1, 1, 0, 0, 3'd1), "pers_fail2");
    push(20,  pk(0, 0, 1, 0, 0, 3'd2), "pers_hold3");
    push(28,  pk(1, 0, 1, 0, 0, 3'd2), "pers_run3");
    push(29,  pk(0, 0, 1, 0, 0, 3'd2), "pers_fail3");
    push(30,  pk(0, 0, 1, 0, 1, 3'd2), "pers_giveup");
    push(140, pk(0, 0, 1, 0, 1, 3'd2), "pers_giveup_held");
    rst = 1'b0;
    wait_edge(141);

    // Force from GIVEUP to PAL, then lock; then a late failure and a
    // force colliding with fail_s in RUN at TRIES=1
    push(142, pk(0, 1, 1, 0, 0, 3'd0), "force_from_giveup");
    push(150, pk(1, 1, 1, 0, 0, 3'd0), "force_en_rise");
    push(166, pk(1, 1, 0, 1, 0, 3'd0), "force_lock");
    push(173, pk(0, 1, 1, 0, 0, 3'd0), "late_fail_state");
    push(174, pk(0, 0, 1, 0, 0, 3'd1), "late_region_flip");
    push(182, pk(1, 0, 1, 0, 0, 3'd1), "retry_run");
    push(185, pk(1, 0, 1, 0, 0, 3'd1), "retry_run_pre");
    push(186, pk(0, 0, 1, 0, 0, 3'd0), "force_vs_fail");
    push(187, pk(0, 0, 1, 0, 0, 3'd0), "no_fail_cycle");
    push(194, pk(1, 0, 1, 0, 0, 3'd0), "post_force_en");
    push(210, pk(1, 0, 0, 1, 0, 3'd0), "post_force_lock");
    cic_fail     = 1'b0;
    force_req    = 1'b1;
    force_region = 1'b1;
    wait_edge(142);
    force_req = 1'b0;
    wait_edge(170);
    cic_fail = 1'b1;
    wait_edge(171);
    cic_fail = 1'b0;
    wait_edge(183);
    cic_fail = 1'b1;
    wait_edge(185);
    cic_fail     = 1'b0;
    force_req    = 1'b1;
    force_region = 1'b0;
    wait_edge(186);
    force_req = 1'b0;
    wait_edge(212);

    tests_run++;
    assert (sb.size() == 0) else begin
      tests_failed++;
      $error("FAIL queue_drained observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cic_region_ctrl.md
# cic_region_ctrl

Sequencer for the CIC lock core and the console region line. It holds the lock core off while the cartridge CIC settles, then releases it and watches for a lock failure. On each failure it flips region and retries, and after a bounded number of attempts it gives up. The system stays in reset until the lock has been stable for a qualification window. It sits between the reset button, the in-game-reset controller (forced region) and the CIC lock core, and replaces ad-hoc retry logic at top level.

## Interface
Parameters:
- SETTLE_CYCLES, 32767: cycles the lock core is held off before each attempt (≥2).
- LOCK_CYCLES, 65535: fail-free cycles in RUN before lock is declared (≥2).
- MAX_TRIES, 4: attempts before giving up (1..8).
- INIT_REGION, 0: region after reset (0 NTSC, 1 PAL).

Ports:
- MCLKO  in  1  master clock; all logic on rising edge.
- RESETI  in  1  reset, asynchronous, active-high.
- CIC_FAIL  in  1  fail flag from the lock core; treated as asynchronous.
- FORCE_REQ  in  1  one-cycle request to restart with a forced region.
- FORCE_REGION  in  1  region to apply with FORCE_REQ.
- CIC_EN  out  1  lock-core enable (pll_locked input of the core).
- REGION  out  1  region drive; 0 NTSC, 1 PAL.
- SYS_HOLD  out  1  1 holds the system in reset.
- LOCKED  out  1  lock qualified.
- GIVEUP  out  1  attempts exhausted.
- TRIES  out  3  index of the current attempt, starting at 0.

## Operation
- CIC_FAIL passes through a 2-flop synchronizer. fail_s is the second flop.
- Counter cnt is wide enough for max(SETTLE_CYCLES, LOCK_CYCLES)-1.
- States and their transitions:
  - HOLD: CIC_EN=0, SYS_HOLD=1. cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to RUN and set cnt=0.
  - RUN: CIC_EN=1, SYS_HOLD=1. If fail_s, go to FAIL. Otherwise cnt increments, and when cnt==LOCK_CYCLES-1, go to LOCKED.
  - LOCKED: CIC_EN=1, SYS_HOLD=0, LOCKED=1. If fail_s, go to FAIL. A late failure consumes an attempt.
  - FAIL: lasts one cycle. CIC_EN=0, SYS_HOLD=1.
    - If TRIES==MAX_TRIES-1, go to GIVEUP with REGION and TRIES unchanged.
    - Otherwise REGION toggles, TRIES increments, cnt=0, and the state goes to HOLD.
  - GIVEUP: CIC_EN=0, SYS_HOLD=1, GIVEUP=1. Terminal until reset or FORCE_REQ.
- FORCE_REQ applies in any state and has priority over fail_s in the same cycle. It sets REGION=FORCE_REGION, TRIES=0, cnt=0, and the state goes to HOLD.
- fail_s is ignored in HOLD, FAIL and GIVEUP.
- All outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- Reset values (asynchronous):
  - state HOLD, cnt 0, synchronizer 0.
  - CIC_EN 0, REGION INIT_REGION, SYS_HOLD 1, LOCKED 0, GIVEUP 0, TRIES 0.

## Timing
- Edges are numbered from the first rising edge after RESETI falls, which is edge 1.
- CIC_EN rises at edge SETTLE_CYCLES.
- With no failure, LOCKED rises and SYS_HOLD falls at edge SETTLE_CYCLES+LOCK_CYCLES.
- Failure latency: a CIC_FAIL rising before edge k gives fail_s at edge k+1.
  - The state is FAIL at edge k+2, and CIC_EN is 0 from that edge.
  - REGION and TRIES update at edge k+3, where the state is HOLD or GIVEUP.
- The next attempt's CIC_EN rises SETTLE_CYCLES edges after HOLD is entered.
- FORCE_REQ sampled at edge k: outputs take their HOLD values at edge k, with REGION=FORCE_REGION and TRIES=0.
- RESETI asserted in any state forces all reset values immediately, without waiting for a clock edge.

## Test plan
All scenarios use SETTLE_CYCLES=8, LOCK_CYCLES=16, MAX_TRIES=3, INIT_REGION=0.
- Clean lock: CIC_FAIL=0 → CIC_EN=1 at edge 8; LOCKED=1 and SYS_HOLD=0 at edge 24; REGION=0, TRIES=0.
- Single failure: CIC_FAIL pulse for 3 cycles during RUN, before edge k.
  - CIC_EN=0 at edge k+2; REGION=1 and TRIES=1 at edge k+3.
  - Lock then qualifies 24 edges after the HOLD entry at k+3.
- Persistent failure: CIC_FAIL=1 from reset.
  - Three attempts are made; REGION goes 0→1→0.
  - Ends with GIVEUP=1, TRIES=2, CIC_EN=0, SYS_HOLD=1 held for over 100 cycles.
- Force from GIVEUP: FORCE_REQ with FORCE_REGION=1.
  - At the same edge: GIVEUP=0, REGION=1, TRIES=0.
  - With CIC_FAIL=0, LOCKED=1 24 edges later.
- Simultaneous events: FORCE_REQ (FORCE_REGION=0) in the same cycle fail_s=1 in RUN with TRIES=1 → state HOLD, TRIES=0, REGION=0, no FAIL cycle.
- Reset mid-operation: RESETI pulse in LOCKED, between clock edges → CIC_EN=0, SYS_HOLD=1, LOCKED=0, REGION=0 immediately, then the clean-lock sequence repeats.
